mem_port_arbiter: RTL and testbench

- Shares the single memory port between the controlpath's instruction fetch (READ_INS) and its data load/store (WAIT_LOAD / WAIT_STORE).
- Generates the wait_instr, wait_data, instr_segv and data_segv handshakes that the controlpath consumes.
- Arbitrates round-robin on ties, bounds-checks every address against MEM_LIMIT, and converts a stalled memory into a segv through a timeout counter.
- Sits between controlpath and the memory model/bus.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Controlpath and memory-side signals of the shared memory port; the arbiter is the slave,
// the controlpath/memory environment is the master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              instr_req;
   logic [ADDR_W-1:0] instr_addr;
   logic [DATA_W-1:0] instruction;
   logic              wait_instr;
   logic              instr_segv;
   logic              ld;
   logic              st;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              wait_data;
   logic              data_segv;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  instr_req, instr_addr, ld, st, data_addr, data_wdata, mem_rdata, mem_ack,
      output instruction, wait_instr, instr_segv, data_rdata, wait_data, data_segv,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output instr_req, instr_addr, ld, st, data_addr, data_wdata, mem_rdata, mem_ack,
      input  instruction, wait_instr, instr_segv, data_rdata, wait_data, data_segv,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with round-robin on ties; request to
// wait-low takes 2 cycles plus the memory ack delay; bad addresses and ack timeouts become segv pulses.
module mem_port_arbiter #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(32'h0001_0000),
   parameter int                TIMEOUT   = 255,
   parameter int                TO_W      = 8
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D, FAULT_I, FAULT_D} state_t;

   state_t            state, state_nxt;
   logic              last_d, last_d_nxt;
   logic [TO_W-1:0]   cnt, cnt_nxt, cnt_inc;
   logic              mem_req, mem_req_nxt;
   logic              mem_we, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr, mem_addr_nxt, sel_addr;
   logic [DATA_W-1:0] mem_wdata, mem_wdata_nxt;
   logic [DATA_W-1:0] instr_q, instr_nxt, rdata_q, rdata_nxt;
   logic              pend_i, pend_d, sel_d, still_pend;

   assign pend_i     = bus.instr_req;
   assign pend_d     = bus.ld | bus.st;
   // last_d remembers who won the previous grant; on a tie the other side goes next
   assign sel_d      = pend_d & (~pend_i | ~last_d);
   assign sel_addr   = sel_d ? bus.data_addr : bus.instr_addr;
   assign cnt_inc    = cnt + TO_W'(1);
   assign still_pend = (state == GRANT_I) ? pend_i : pend_d;

   always_comb begin
      state_nxt     = state;
      last_d_nxt    = last_d;
      cnt_nxt       = cnt;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      instr_nxt     = instr_q;
      rdata_nxt     = rdata_q;
      unique case (state)
         IDLE: begin
            if (pend_i | pend_d) begin
               if (sel_addr >= MEM_LIMIT || (sel_d && bus.ld && bus.st)) begin
                  state_nxt = sel_d ? FAULT_D : FAULT_I;
               end else begin
                  state_nxt     = sel_d ? GRANT_D : GRANT_I;
                  last_d_nxt    = sel_d;
                  cnt_nxt       = '0;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = sel_d & bus.st;
                  mem_addr_nxt  = sel_addr;
                  mem_wdata_nxt = sel_d ? bus.data_wdata : '0;
               end
            end
         end
         GRANT_I, GRANT_D: begin
            if (bus.mem_ack) begin
               mem_req_nxt = 1'b0;
               if (state == GRANT_I) instr_nxt = bus.mem_rdata;
               else if (!mem_we)     rdata_nxt = bus.mem_rdata;
               // a withdrawn request has nobody waiting, so skip the handshake cycle
               if (still_pend) state_nxt = (state == GRANT_I) ? DONE_I : DONE_D;
               else            state_nxt = IDLE;
            end else if (cnt_inc == TO_W'(TIMEOUT)) begin
               mem_req_nxt = 1'b0;
               if (still_pend) state_nxt = (state == GRANT_I) ? FAULT_I : FAULT_D;
               else            state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         instr_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state     <= state_nxt;
         last_d    <= last_d_nxt;
         cnt       <= cnt_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         instr_q   <= instr_nxt;
         rdata_q   <= rdata_nxt;
      end
   end

   assign bus.wait_instr  = pend_i & ~(state == DONE_I || state == FAULT_I);
   assign bus.wait_data   = pend_d & ~(state == DONE_D || state == FAULT_D);
   assign bus.instr_segv  = (state == FAULT_I);
   assign bus.data_segv   = (state == FAULT_D);
   assign bus.instruction = instr_q;
   assign bus.data_rdata  = rdata_q;
   assign bus.mem_req     = mem_req;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized controlpath/memory stimulus against a transaction-level model, plus directed scenarios.
module tb_mem_port_arbiter;
   localparam logic [31:0] LIMIT = 32'h0001_0000;
   localparam int          TO    = 20;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   cmp_en = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LIMIT(LIMIT), .TIMEOUT(TO), .TO_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // model: owner of the in-flight access (0 none, 1 fetch, 2 data), one-cycle response slot
   int          m_own, m_age, m_resp, m_who;
   bit          m_last_d, m_ifin, m_dfin;
   logic        e_req, e_we;
   logic [31:0] e_addr, e_wdata, e_instr, e_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_own = 0; m_age = 0; m_resp = 0; m_who = 0; m_last_d = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_instr = 0; e_rdata = 0;
   endtask

   task automatic model_step();
      bit pi, pd, sd, still;
      logic [31:0] a;
      pi = bus.instr_req;
      pd = bus.ld | bus.st;
      m_ifin = (m_resp != 0 && m_who == 1);
      m_dfin = (m_resp != 0 && m_who == 2);
      if (m_resp != 0) begin
         m_resp = 0;
      end else if (m_own != 0) begin
         still = (m_own == 1) ? pi : pd;
         if (bus.mem_ack) begin
            if (m_own == 1) e_instr = bus.mem_rdata;
            else if (!e_we) e_rdata = bus.mem_rdata;
            e_req = 0;
            if (still) begin m_resp = 1; m_who = m_own; end
            m_own = 0;
         end else begin
            m_age++;
            if (m_age == TO) begin
               e_req = 0;
               if (still) begin m_resp = 2; m_who = m_own; end
               m_own = 0;
            end
         end
      end else if (pi || pd) begin
         sd = pd && (!pi || !m_last_d);
         a  = sd ? bus.data_addr : bus.instr_addr;
         if (a >= LIMIT || (sd && bus.ld && bus.st)) begin
            m_resp = 2; m_who = sd ? 2 : 1;
         end else begin
            m_own = sd ? 2 : 1; m_age = 0; m_last_d = sd;
            e_req = 1; e_we = sd && bus.st; e_addr = a;
            e_wdata = sd ? bus.data_wdata : 32'h0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("wait_instr", bus.wait_instr, bus.instr_req && !(m_resp != 0 && m_who == 1));
         chk("wait_data",  bus.wait_data,  (bus.ld || bus.st) && !(m_resp != 0 && m_who == 2));
         chk("instr_segv", bus.instr_segv, m_resp == 2 && m_who == 1);
         chk("data_segv",  bus.data_segv,  m_resp == 2 && m_who == 2);
         chk("mem_req",    bus.mem_req,    e_req);
         chk("instruction", bus.instruction, e_instr);
         chk("data_rdata", bus.data_rdata, e_rdata);
         if (e_req) begin
            chk("mem_we",    bus.mem_we,    e_we);
            chk("mem_addr",  bus.mem_addr,  e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      bus.instr_req = 0; bus.instr_addr = 0; bus.ld = 0; bus.st = 0;
      bus.data_addr = 0; bus.data_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
   endtask

   task automatic do_reset();
      cmp_en = 0;
      rst_n  = 0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1;
      cmp_en = 1;
   endtask

   // request in cycle 0, ack driven in cycle 2, wait must be low in cycle 3
   task automatic directed(input string tag, input bit i, input bit l, input bit s,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
      bus.instr_req = i; bus.ld = l; bus.st = s; bus.mem_ack = 0;
      if (i) bus.instr_addr = a; else bus.data_addr = a;
      bus.data_wdata = wd;
      @(negedge clk); chk({tag, "_wait_c0"}, i ? bus.wait_instr : bus.wait_data, 1);
      step();
      @(negedge clk);
      chk({tag, "_req_c1"}, bus.mem_req, 1);
      chk({tag, "_we_c1"}, bus.mem_we, s);
      chk({tag, "_addr_c1"}, bus.mem_addr, a);
      if (s) chk({tag, "_wdata_c1"}, bus.mem_wdata, wd);
      step(); bus.mem_ack = 1; bus.mem_rdata = rd;
      @(negedge clk); chk({tag, "_wait_c2"}, i ? bus.wait_instr : bus.wait_data, 1);
      step(); bus.mem_ack = 0;
      @(negedge clk); chk({tag, "_wait_c3"}, i ? bus.wait_instr : bus.wait_data, 0);
      step(); bus.instr_req = 0; bus.ld = 0; bus.st = 0;
      step();
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 15))
         0:       return LIMIT;
         1:       return LIMIT - 32'd4;
         2:       return LIMIT + ($urandom & 32'h00FF_FFFC);
         default: return $urandom_range(0, 32'h3FFF) << 2;
      endcase
   endfunction

   task automatic gen();
      int k;
      if (!bus.instr_req) begin
         if ($urandom_range(0, 2) == 0) begin bus.instr_req = 1; bus.instr_addr = rand_addr(); end
      end else if (m_ifin && $urandom_range(0, 3) != 0) begin
         bus.instr_req = 0;
      end
      if (!(bus.ld || bus.st)) begin
         if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 15);
            bus.ld = (k < 9 || k == 15);
            bus.st = (k >= 9);
            bus.data_addr  = rand_addr();
            bus.data_wdata = $urandom;
         end
      end else if (m_dfin && $urandom_range(0, 3) != 0) begin
         bus.ld = 0; bus.st = 0;
      end
      bus.mem_ack   = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
   endtask

   initial begin
      logic [31:0] grants [4];
      int          ng, req_cycles, segs;
      bit          prev, seen;

      rst_n = 0;
      clear_inputs();
      model_reset();
      #3;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_instruction", bus.instruction, 0);
      chk("rst_data_rdata", bus.data_rdata, 0);
      chk("rst_instr_segv", bus.instr_segv, 0);
      chk("rst_data_segv", bus.data_segv, 0);
      do_reset();

      directed("fetch", 1, 0, 0, 32'h0, 32'h0, 32'h8080_1234);
      chk("fetch_instruction", bus.instruction, 32'h8080_1234);
      directed("load", 0, 1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF);
      chk("load_rdata", bus.data_rdata, 32'hDEAD_BEEF);
      directed("store", 0, 0, 1, 32'h104, 32'hCAFE_F00D, 32'h1111_1111);
      chk("store_keeps_rdata", bus.data_rdata, 32'hDEAD_BEEF);

      // bad fetch address: segv one cycle after the request, never a memory request
      bus.instr_req = 1; bus.instr_addr = LIMIT;
      @(negedge clk); chk("ifault_c0_segv", bus.instr_segv, 0);
      step();
      @(negedge clk);
      chk("ifault_c1_segv", bus.instr_segv, 1);
      chk("ifault_c1_wait", bus.wait_instr, 0);
      chk("ifault_c1_req", bus.mem_req, 0);
      step(); bus.instr_req = 0;
      @(negedge clk); chk("ifault_c2_segv", bus.instr_segv, 0);
      step();

      // both requesters held with memory always acking: grants alternate starting with data
      do_reset();
      bus.instr_addr = 32'h40; bus.data_addr = 32'h300;
      bus.instr_req = 1; bus.ld = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h5555_AAAA;
      ng = 0; prev = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         if (bus.mem_req && !prev && ng < 4) begin grants[ng] = bus.mem_addr; ng++; end
         prev = bus.mem_req;
         step();
      end
      chk("tie_grant_count", ng, 4);
      chk("tie_grant0", (ng > 0) ? grants[0] : 32'hFFFF_FFFF, 32'h300);
      chk("tie_grant1", (ng > 1) ? grants[1] : 32'hFFFF_FFFF, 32'h40);
      chk("tie_grant2", (ng > 2) ? grants[2] : 32'hFFFF_FFFF, 32'h300);
      chk("tie_grant3", (ng > 3) ? grants[3] : 32'hFFFF_FFFF, 32'h40);
      bus.instr_req = 0; bus.ld = 0;
      step(); bus.mem_ack = 0;
      step();

      // memory never acks: request held for TIMEOUT cycles, then a single data segv
      bus.ld = 1; bus.data_addr = 32'h200;
      req_cycles = 0; segs = 0; seen = 0;
      for (int c = 0; c < TO + 10; c++) begin
         @(negedge clk);
         if (bus.mem_req) req_cycles++;
         if (bus.data_segv) begin segs++; seen = 1; end
         step();
         if (seen) bus.ld = 0;
      end
      chk("timeout_req_cycles", req_cycles, TO);
      chk("timeout_segv_pulses", segs, 1);

      // asynchronous reset in the middle of a grant
      bus.ld = 1; bus.data_addr = 32'h100;
      step();
      @(negedge clk); chk("midrst_req_before", bus.mem_req, 1);
      #1;
      cmp_en = 0; rst_n = 0;
      #1;
      chk("midrst_req", bus.mem_req, 0);
      chk("midrst_addr", bus.mem_addr, 0);
      chk("midrst_instruction", bus.instruction, 0);
      chk("midrst_rdata", bus.data_rdata, 0);
      chk("midrst_dsegv", bus.data_segv, 0);
      do_reset();

      for (int n = 0; n < 3000; n++) begin
         step();
         gen();
      end
      clear_inputs();
      repeat (TO + 4) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
